// File: rtl/timer_mch_pkg.sv
// Shared definitions for the multi-channel APB timer: register map, TCR layout
// and the prescaler divide encoding.
package timer_mch_pkg;

  localparam logic [3:0] TCR_OFF  = 4'h0;
  localparam logic [3:0] TDR_OFF  = 4'h4;
  localparam logic [3:0] TRLD_OFF = 4'h8;
  localparam logic [3:0] TSR_OFF  = 4'hC;
  localparam int         CH_STRIDE = 'h10;

  localparam int TCR_EN_BIT     = 0;
  localparam int TCR_UD_BIT     = 1;
  localparam int TCR_CKS_LSB    = 2;
  localparam int TCR_CKS_MSB    = 4;
  localparam int TCR_ARL_BIT    = 5;
  localparam int TCR_OVF_IE_BIT = 6;
  localparam int TCR_UDF_IE_BIT = 7;
  localparam int TCR_W          = 8;

  localparam int TSR_OVF_BIT = 0;
  localparam int TSR_UDF_BIT = 1;

  localparam int PSC_W = 7;

  typedef enum logic [2:0] {
    CKS_DIV1   = 3'd0,
    CKS_DIV2   = 3'd1,
    CKS_DIV4   = 3'd2,
    CKS_DIV8   = 3'd3,
    CKS_DIV16  = 3'd4,
    CKS_DIV32  = 3'd5,
    CKS_DIV64  = 3'd6,
    CKS_DIV128 = 3'd7
  } cks_e;

  typedef struct packed {
    logic udf_ie;
    logic ovf_ie;
    logic arl;
    cks_e cks;
    logic ud;
    logic en;
  } tcr_t;

  // Prescaler value on which a tick fires: 2^cks - 1.
  function automatic logic [PSC_W-1:0] cks_last(input cks_e cks);
    return PSC_W'((8'd1 << cks) - 8'd1);
  endfunction

endpackage

// File: rtl/timer_mch_ch.sv
// One timer channel: control/reload/status registers, 7-bit prescaler,
// up/down counter with optional auto-reload and level interrupt.
module timer_mch_ch
  import timer_mch_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_tcr_i,
  input  logic             wr_tdr_i,
  input  logic             wr_trld_i,
  input  logic             wr_tsr_i,
  input  logic [31:0]      wdata_i,
  output tcr_t             tcr_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] rld_o,
  output logic [1:0]       tsr_o,
  output logic             irq_o
);

  tcr_t             tcr_q, tcr_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rld_q, rld_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             tick;
  logic             ovf_set;
  logic             udf_set;
  logic             unused_wdata;

  assign unused_wdata = ^wdata_i;

  assign tick = tcr_q.en && (psc_q == cks_last(tcr_q.cks));

  always_comb begin
    tcr_d = wr_tcr_i  ? tcr_t'(wdata_i[TCR_W-1:0]) : tcr_q;
    rld_d = wr_trld_i ? wdata_i[CNT_W-1:0]         : rld_q;

    if (!tcr_q.en || tick) psc_d = '0;
    else                   psc_d = psc_q + PSC_W'(1);
    // A new divide ratio restarts the phase so the next tick is a full period away.
    if (wr_tcr_i && (tcr_d.cks != tcr_q.cks)) psc_d = '0;

    cnt_d   = cnt_q;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    if (wr_tdr_i) begin
      cnt_d = wdata_i[CNT_W-1:0];
    end else if (tick) begin
      if (!tcr_q.ud) begin
        if (cnt_q == '1) begin
          ovf_set = 1'b1;
          cnt_d   = tcr_q.arl ? rld_q : '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        if (cnt_q == '0) begin
          udf_set = 1'b1;
          cnt_d   = tcr_q.arl ? rld_q : '1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    end

    // W1C loses against a same-cycle set.
    ovf_d = (ovf_q & ~(wr_tsr_i & wdata_i[TSR_OVF_BIT])) | ovf_set;
    udf_d = (udf_q & ~(wr_tsr_i & wdata_i[TSR_UDF_BIT])) | udf_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcr_q <= '0;
      psc_q <= '0;
      cnt_q <= '0;
      rld_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      tcr_q <= tcr_d;
      psc_q <= psc_d;
      cnt_q <= cnt_d;
      rld_q <= rld_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign tcr_o = tcr_q;
  assign cnt_o = cnt_q;
  assign rld_o = rld_q;
  assign tsr_o = {udf_q, ovf_q};
  assign irq_o = (ovf_q & tcr_q.ovf_ie) | (udf_q & tcr_q.udf_ie);

endmodule

// File: rtl/timer_mch_apb.sv
// APB slave wrapper for NUM_CH timer channels: address decode, write strobes,
// combinational read mux and error response for unmapped addresses.
module timer_mch_apb
  import timer_mch_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [11:0]       paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [NUM_CH-1:0] irq
);

  logic             access;
  logic             mapped;
  logic             wr_en;
  logic [7:0]       ch_idx;
  logic [3:0]       reg_off;
  logic [31:0]      rdata;
  logic             unused_addr;

  tcr_t             tcr_a [NUM_CH];
  logic [CNT_W-1:0] cnt_a [NUM_CH];
  logic [CNT_W-1:0] rld_a [NUM_CH];
  logic [1:0]       tsr_a [NUM_CH];

  assign unused_addr = ^paddr[1:0];

  assign access  = psel & penable;
  assign mapped  = (32'(paddr) < 32'(NUM_CH * CH_STRIDE));
  assign wr_en   = access & pwrite & mapped;
  assign ch_idx  = paddr[11:4];
  assign reg_off = {paddr[3:2], 2'b00};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic hit;
    assign hit = wr_en && (ch_idx == 8'(g));

    timer_mch_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .wr_tcr_i  (hit && (reg_off == TCR_OFF)),
      .wr_tdr_i  (hit && (reg_off == TDR_OFF)),
      .wr_trld_i (hit && (reg_off == TRLD_OFF)),
      .wr_tsr_i  (hit && (reg_off == TSR_OFF)),
      .wdata_i   (pwdata),
      .tcr_o     (tcr_a[g]),
      .cnt_o     (cnt_a[g]),
      .rld_o     (rld_a[g]),
      .tsr_o     (tsr_a[g]),
      .irq_o     (irq[g])
    );
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx == 8'(i)) begin
        case (reg_off)
          TCR_OFF:  rdata = {24'd0, tcr_a[i]};
          TDR_OFF:  rdata = 32'(cnt_a[i]);
          TRLD_OFF: rdata = 32'(rld_a[i]);
          default:  rdata = {30'd0, tsr_a[i]};
        endcase
      end
    end
  end

  // Bus outputs are forced quiet while reset is held, independent of psel.
  assign prdata  = (access && mapped && !rst) ? rdata : 32'd0;
  assign pslverr = access && !mapped && !rst;
  assign pready  = 1'b1;

endmodule

// File: tb/tb_timer_mch_apb.sv
// Self-checking bench for timer_mch_apb: directed scenarios followed by random
// APB traffic, all compared against a cycle-level behavioural model.
module tb_timer_mch_apb;

  localparam int     NUM_CH = 2;
  localparam int     CNT_W  = 16;
  localparam longint MAXV   = (64'd1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              psel = 1'b0;
  logic              penable = 1'b0;
  logic              pwrite = 1'b0;
  logic [11:0]       paddr = '0;
  logic [31:0]       pwdata = '0;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;
  logic [NUM_CH-1:0] irq;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_tcr [NUM_CH];
  longint     m_cnt [NUM_CH];
  longint     m_rld [NUM_CH];
  bit         m_ovf [NUM_CH];
  bit         m_udf [NUM_CH];
  int         m_age [NUM_CH];

  logic [31:0] d;
  logic [11:0] a;
  int          op;
  int          c;

  always #5 clk = ~clk;

  timer_mch_apb #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .irq     (irq)
  );

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_tcr[i] = '0; m_cnt[i] = 0; m_rld[i] = 0;
      m_ovf[i] = 0;  m_udf[i] = 0; m_age[i] = 0;
    end
  endfunction

  // One clock edge of the reference: every channel sees the same bus inputs.
  function automatic void model_step();
    bit acc;
    int ch;
    int off;
    acc = psel && penable && pwrite;
    ch  = int'(paddr[11:4]);
    off = int'(paddr[3:2]);
    for (int i = 0; i < NUM_CH; i++) begin
      bit     en, ud, arl, tick, wr, set_o, set_u;
      int     per, age_n;
      longint nxt;
      en    = m_tcr[i][0];
      ud    = m_tcr[i][1];
      arl   = m_tcr[i][5];
      per   = 1 << m_tcr[i][4:2];
      tick  = en && ((m_age[i] % per) == per - 1);
      wr    = acc && (ch == i);
      age_n = en ? m_age[i] + 1 : 0;
      set_o = 0;
      set_u = 0;
      if (wr && off == 1) begin
        m_cnt[i] = longint'(pwdata) & MAXV;
      end else if (tick) begin
        nxt = m_cnt[i] + (ud ? -1 : 1);
        if (nxt > MAXV) set_o = 1;
        if (nxt < 0)    set_u = 1;
        if ((set_o || set_u) && arl) nxt = m_rld[i];
        m_cnt[i] = nxt & MAXV;
      end
      if (wr && off == 3) begin
        if (pwdata[0]) m_ovf[i] = 0;
        if (pwdata[1]) m_udf[i] = 0;
      end
      if (set_o) m_ovf[i] = 1;
      if (set_u) m_udf[i] = 1;
      if (wr && off == 2) m_rld[i] = longint'(pwdata) & MAXV;
      if (wr && off == 0) begin
        if (pwdata[4:2] != m_tcr[i][4:2]) age_n = 0;
        m_tcr[i] = pwdata[7:0];
      end
      m_age[i] = age_n;
    end
  endfunction

  function automatic logic [NUM_CH-1:0] m_irq();
    logic [NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++)
      v[i] = (m_ovf[i] && m_tcr[i][6]) || (m_udf[i] && m_tcr[i][7]);
    return v;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] ad);
    int i;
    if (int'(ad) >= NUM_CH * 16) return 32'h0;
    i = int'(ad[11:4]);
    case (ad[3:2])
      2'd0:    return {24'h0, m_tcr[i]};
      2'd1:    return 32'(m_cnt[i]);
      2'd2:    return 32'(m_rld[i]);
      default: return {30'h0, m_udf[i], m_ovf[i]};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1;
    chk("irq", 32'(irq), 32'(m_irq()));
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input logic [11:0] ad, input logic [31:0] dat);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = ad; pwdata = dat;
    step();
    penable = 1'b1;
    step();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  // use_x selects a fixed expected value instead of the model's register image.
  task automatic rd(input string tag, input logic [11:0] ad, input bit use_x, input logic [31:0] x);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = ad;
    step();
    chk({tag, "_setup"}, prdata, 32'h0);
    penable = 1'b1;
    #1;
    chk(tag, prdata, use_x ? x : m_read(ad));
    chk({tag, "_err"}, 32'(pslverr), (int'(ad) >= NUM_CH * 16) ? 32'd1 : 32'd0);
    chk({tag, "_rdy"}, 32'(pready), 32'd1);
    step();
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic do_reset(input bit busy);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_irq", 32'(irq), 32'h0);
    if (busy) begin
      psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 12'h004;
      #1;
      chk("rst_prdata", prdata, 32'h0);
      paddr = 12'h024;
      #1;
      chk("rst_pslverr", 32'(pslverr), 32'h0);
      pwrite = 1'b1; paddr = 12'h004; pwdata = 32'h0000_AAAA;
    end
    step();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    idle(3);
    rst = 1'b0;

    // Reset values and reserved bits.
    for (int ch = 0; ch < 2; ch++)
      for (int o = 0; o < 4; o++)
        rd($sformatf("rst_ch%0d_off%0h", ch, o * 4), 12'(ch * 16 + o * 4), 1'b1, 32'h0);
    wr(12'h000, 32'hFFFF_FFFF);
    rd("tcr_mask", 12'h000, 1'b1, 32'h0000_00FF);
    rd("unmapped", 12'h020, 1'b1, 32'h0);
    do_reset(1'b0);

    // Up count at divide-by-4 through the wrap.
    wr(12'h004, 32'h0000_FFFD);
    wr(12'h000, 32'h0000_0049);
    idle(3);
    rd("up_fffe", 12'h004, 1'b1, 32'h0000_FFFE);
    idle(2);
    rd("up_ffff", 12'h004, 1'b1, 32'h0000_FFFF);
    idle(2);
    rd("up_wrap", 12'h004, 1'b1, 32'h0000_0000);
    chk("up_irq0", 32'(irq[0]), 32'd1);
    rd("up_tsr", 12'h00C, 1'b1, 32'h1);

    // Down count with auto-reload at divide-by-1, then clear the flag.
    wr(12'h000, 32'h0);
    wr(12'h00C, 32'h3);
    wr(12'h008, 32'h0000_0010);
    wr(12'h004, 32'h0000_0001);
    wr(12'h000, 32'h0000_00A3);
    rd("dn_zero", 12'h004, 1'b1, 32'h0);
    rd("dn_tsr", 12'h00C, 1'b1, 32'h2);
    wr(12'h00C, 32'h2);
    chk("dn_irq_clr", 32'(irq[0]), 32'd0);
    rd("dn_cnt", 12'h004, 1'b0, 32'h0);
    wr(12'h000, 32'h0);

    // Direction change mid-count on channel 1 at divide-by-2.
    wr(12'h014, 32'h3);
    wr(12'h010, 32'h5);
    idle(3);
    wr(12'h010, 32'h7);
    rd("ud_switch", 12'h014, 1'b1, 32'h4);

    // Counter load colliding with an overflow tick.
    wr(12'h00C, 32'h3);
    wr(12'h004, 32'h0000_FFFF);
    wr(12'h000, 32'h5);
    wr(12'h004, 32'h0000_1234);
    rd("col_tdr", 12'h004, 1'b1, 32'h0000_1234);
    rd("col_tsr", 12'h00C, 1'b1, 32'h0);

    // Flag clear colliding with an overflow set on channel 1.
    wr(12'h010, 32'h0);
    wr(12'h01C, 32'h3);
    wr(12'h014, 32'h0000_FFFF);
    wr(12'h010, 32'h45);
    wr(12'h01C, 32'h3);
    rd("w1c_tsr", 12'h01C, 1'b1, 32'h1);
    chk("w1c_irq1", 32'(irq[1]), 32'd1);

    // Asynchronous reset while both channels run at divide-by-8.
    wr(12'h000, 32'h0000_004D);
    wr(12'h010, 32'h0000_004D);
    idle(13);
    do_reset(1'b1);
    for (int ch = 0; ch < 2; ch++)
      for (int o = 0; o < 4; o++)
        rd($sformatf("rrst_ch%0d_off%0h", ch, o * 4), 12'(ch * 16 + o * 4), 1'b1, 32'h0);
    idle(20);
    rd("rrst_idle", 12'h004, 1'b1, 32'h0);
    wr(12'h000, 32'h0000_000D);
    idle(17);
    rd("rrst_resume", 12'h004, 1'b0, 32'h0);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      op = int'($urandom_range(0, 9));
      c  = int'($urandom_range(0, NUM_CH));
      a  = 12'(c * 16 + int'($urandom_range(0, 3)) * 4);
      case (op)
        0, 1: begin
          d = $urandom;
          d[4:2] = 3'($urandom_range(0, 2));
          wr(12'(c * 16), d);
        end
        2: begin
          case ($urandom_range(0, 3))
            0:       d = 32'h0000_FFFF;
            1:       d = 32'h0;
            2:       d = 32'h0000_FFFE;
            default: d = $urandom;
          endcase
          wr(12'(c * 16 + 4), d);
        end
        3: wr(12'(c * 16 + 8), $urandom_range(0, 40));
        4: wr(12'(c * 16 + 12), $urandom);
        5, 6, 7: rd("rnd_rd", a, 1'b0, 32'h0);
        8: idle(int'($urandom_range(1, 6)));
        default: begin
          a = 12'($urandom_range(0, 4095));
          if ($urandom_range(0, 1) == 1) wr(a, $urandom);
          else                           rd("rnd_any", a, 1'b0, 32'h0);
        end
      endcase
    end

    for (int ch = 0; ch < NUM_CH; ch++)
      for (int o = 0; o < 4; o++)
        rd("final", 12'(ch * 16 + o * 4), 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
